// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: IF/ID instruction in,
// stall/flush controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             branch_taken;
  logic             reg2loc;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_in, instr_valid, branch_taken,
    input  reg2loc, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_in, instr_valid, branch_taken,
    output reg2loc, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// LEGv8 5-stage hazard/sequencing controller: decodes IF/ID, tracks in-flight
// destinations (EX/MEM/WB), and issues stall, bubble and branch-flush controls.
module hazard_ctrl #(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [4:0]  XZR       = 5'd31;
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state, state_next;
  sb_entry_t  sb_ex, sb_mem, sb_wb, id_entry;
  logic       is_r, is_ldur, is_stur, is_cbz;
  logic [4:0] src1, src2;
  logic       use1, use2;
  logic       sel_rt, hazard, stall, issue;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // WB is tracked for completeness; the register file writes before it is read.
  logic unused_sb;
  assign unused_sb = ^{sb_wb, bus.instr_in[15:10]};

  function automatic logic hits(sb_entry_t e, logic [4:0] s1, logic u1,
                                logic [4:0] s2, logic u2);
    return e.v & ((u1 & (e.rd == s1)) | (u2 & (e.rd == s2)));
  endfunction

  // Decode of the instruction held in IF/ID
  always_comb begin
    is_r     = (bus.instr_in[31:21] == OP_ADD) || (bus.instr_in[31:21] == OP_SUB) ||
               (bus.instr_in[31:21] == OP_AND) || (bus.instr_in[31:21] == OP_ORR);
    is_ldur  = (bus.instr_in[31:21] == OP_LDUR);
    is_stur  = (bus.instr_in[31:21] == OP_STUR);
    is_cbz   = (bus.instr_in[31:24] == OP_CBZ);
    sel_rt   = bus.instr_valid & (is_stur | is_cbz);
    src1     = bus.instr_in[9:5];
    src2     = sel_rt ? bus.instr_in[4:0] : bus.instr_in[20:16];
    use1     = bus.instr_valid & (is_r | is_ldur | is_stur) & (src1 != XZR);
    use2     = bus.instr_valid & (is_r | is_stur | is_cbz) & (src2 != XZR);
    id_entry.v  = bus.instr_valid & (is_r | is_ldur) & (bus.instr_in[4:0] != XZR);
    id_entry.rd = bus.instr_in[4:0];
    id_entry.ld = is_ldur;
  end

  // RAW detection; a flushed IF/ID never stalls
  always_comb begin
    hazard = 1'b0;
    if (FORWARDING)
      hazard = sb_ex.ld & hits(sb_ex, src1, use1, src2, use2);
    else
      hazard = hits(sb_ex, src1, use1, src2, use2) | hits(sb_mem, src1, use1, src2, use2);
    if (state == FLUSH)
      hazard = 1'b0;
  end

  assign stall = bus.instr_valid & hazard & ~bus.branch_taken;
  assign issue = bus.instr_valid & ~stall & ~bus.branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = RUN;
    bus.reg2loc      = sel_rt;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.id_ex_bubble = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    if (bus.branch_taken) begin
      state_next       = FLUSH;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (stall) begin
      state_next       = STALL;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  // In-flight destination scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= bus.branch_taken ? sb_entry_t'(7'd0) : sb_ex;
      sb_ex  <= issue ? id_entry : sb_entry_t'(7'd0);
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.branch_taken && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage LEGv8 core; sits beside the IF/ID register and the register-file read-address mux.
- Decodes the instruction held in IF/ID and drives the read-port-2 select (reg2loc).
- Tracks in-flight destination registers in an internal 3-entry scoreboard (EX, MEM, WB).
- Issues PC/IF-ID stall, ID/EX bubble and branch-flush controls; keeps saturating stall and flush counters.

Parameters:
FORWARDING, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against the EX or MEM entry.
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_in  input  32  instruction currently held in IF/ID (PR1[31:0])
instr_valid  input  1  IF/ID holds a real instruction
branch_taken  input  1  branch resolved taken in MEM this cycle
reg2loc  output  1  0 = read port 2 takes [20:16]; 1 = read port 2 takes [4:0]
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
id_ex_bubble  output  1  zero ID/EX control fields this cycle
if_id_flush  output  1  clear IF/ID
id_ex_flush  output  1  clear ID/EX
ex_mem_flush  output  1  clear EX/MEM
stall_cnt  output  CNT_W  stall cycles, saturating
flush_cnt  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- Decode classes:
  - R-type = [31:21] in {10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR}; sources Rn[9:5] and Rm[20:16]; dest Rd[4:0].
  - LDUR 11111000010: source Rn; dest Rt[4:0]; is_load.
  - STUR 11111000000: sources Rn and Rt[4:0]; no dest.
  - CBZ ([31:24]=10110100): source Rt only.
  - B ([31:26]=000101): no sources.
  - Any other encoding: no sources, no dest.
- reg2loc is combinational: 1 for STUR and CBZ, else 0. It is 0 when instr_valid=0.
- Register 31 (XZR) never creates a hazard, as a source or as a destination.
- Scoreboard entry = {v, rd[4:0], ld}. All entries are invalid after reset.
- hazard, combinational:
  - FORWARDING=1: EX entry has v & ld and rd matches a used source.
  - FORWARDING=0: EX or MEM entry is valid and rd matches a used source.
  - The WB entry never causes a hazard (the register file writes before it is read).
- stall = instr_valid & hazard & ~branch_taken.
- During stall: pc_write=0, if_id_write=0, id_ex_bubble=1. Otherwise pc_write=if_id_write=1 and id_ex_bubble=0.
- On branch_taken: if_id_flush, id_ex_flush and ex_mem_flush are all 1 in the same cycle. pc_write=1, so the PC takes the target.
- branch_taken has priority over stall when both occur in the same cycle.
- Scoreboard update, every rising edge:
  - WB <= MEM.
  - MEM <= EX, or invalid if branch_taken.
  - EX <= decoded ID entry when issue = instr_valid & ~stall & ~branch_taken; otherwise invalid.
- Control state machine, registered, 2 bits:
  - States: RUN; STALL (stall asserted last cycle); FLUSH (branch_taken last cycle).
  - Transitions: branch_taken -> FLUSH; else stall -> STALL; else RUN.
  - While in FLUSH, hazard checking is suppressed, because IF/ID holds a flushed bubble.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each branch_taken cycle.
  - Both saturate at all-ones.
- Latency: every control output is combinational, in the same cycle as its cause.
- Reset, asynchronous, at any time (mid-stall or mid-flush included):
  - Scoreboard invalid, state = RUN, both counters = 0.
  - Outputs then settle to pc_write=1, if_id_write=1, and id_ex_bubble/flushes=0 unless branch_taken.

Test Plan:
- Load-use: LDUR X2,[X1,#0] then ADD X3,X2,X4, FORWARDING=1 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; ADD issues next cycle; stall_cnt=1.
- Store select: STUR X5,[X6,#8] in IF/ID -> reg2loc=1; ADD X1,X2,X3 -> reg2loc=0; CBZ X7 -> reg2loc=1, with no hazard against a pending write to X0 in its Rn field.
- XZR: LDUR XZR,[X1] then ADD X3,XZR,X4 -> no stall.
- No-forwarding build: FORWARDING=0, ADD X2,X1,X1 then SUB X4,X2,X3 -> 2 stall cycles, then issue; stall_cnt=2.
- Branch during stall: branch_taken=1 in the cycle a load-use stall would occur -> all three flushes =1, pc_write=1, no stall, flush_cnt=1; the next cycle shows no hazard.
- Async reset mid-stall, then counter saturation with CNT_W=4 -> outputs return to run values at once; after 20 forced stalls stall_cnt=15.
